// File: rtl/stream_matcher.sv
// Byte-stream pattern matcher: compares each newly accepted 8-byte window against a
// masked 8-character pattern and reports a match pulse plus a sticky flag and count.
module stream_matcher #(
  parameter bit SATURATE = 1'b1,
  parameter bit OVERLAP  = 1'b1
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tdata,
  input  logic [63:0] characters,
  input  logic [63:0] masks,
  input  logic        clear,
  output logic        match,
  output logic [7:0]  result
);

  localparam int DATA_W = 8;
  localparam int STAGES = 8;

  logic [DATA_W-1:0] hist_q [STAGES];
  logic [DATA_W-1:0] hist_d [STAGES];
  logic [STAGES-1:0] hv_q, hv_d;
  logic              eval_q, eval_d;
  logic              match_q, match_d;
  logic [6:0]        count_q, count_d;
  logic              sticky_q, sticky_d;

  logic [STAGES-1:0] slot_hit;
  logic              window_hit;
  logic              fire;
  logic [STAGES-1:0] hv_base;

  function automatic logic [6:0] count_inc(input logic [6:0] c);
    if (c == 7'h7F) begin
      return SATURATE ? 7'h7F : 7'h00;
    end
    return c + 7'd1;
  endfunction

  // Slot compare: an all-zero mask is a don't-care slot, valid or not.
  always_comb begin
    slot_hit = '0;
    for (int k = 0; k < STAGES; k++) begin
      slot_hit[k] = (masks[8*k +: 8] == 8'h00) ||
                    (hv_q[k] && (((hist_q[k] ^ characters[8*k +: 8]) & masks[8*k +: 8]) == 8'h00));
    end
    window_hit = &slot_hit;
  end

  assign fire = eval_q && window_hit;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      hist_d[k] = hist_q[k];
    end
    hv_base  = hv_q;
    hv_d     = hv_q;
    eval_d   = 1'b0;
    match_d  = 1'b0;
    count_d  = count_q;
    sticky_d = sticky_q;
    if (clear) begin
      hv_d     = '0;
      count_d  = '0;
      sticky_d = 1'b0;
    end else begin
      if (fire) begin
        match_d  = 1'b1;
        count_d  = count_inc(count_q);
        sticky_d = 1'b1;
        if (!OVERLAP) begin
          hv_base = '0;
        end
      end
      hv_d = hv_base;
      if (s_axis_tvalid) begin
        for (int k = 0; k < STAGES - 1; k++) begin
          hist_d[k] = hist_q[k+1];
        end
        hist_d[STAGES-1] = s_axis_tdata;
        hv_d   = {1'b1, hv_base[STAGES-1:1]};
        eval_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        hist_q[k] <= '0;
      end
      hv_q     <= '0;
      eval_q   <= 1'b0;
      match_q  <= 1'b0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        hist_q[k] <= hist_d[k];
      end
      hv_q     <= hv_d;
      eval_q   <= eval_d;
      match_q  <= match_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  assign match  = match_q;
  assign result = {sticky_q, count_q};

endmodule
